// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter: register index, data word
// and the buffered writeback request.
package regfile_wb_arbiter_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    reg_idx_t rd;
    word_t    data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer of MDU writeback requests; head is readable combinationally.
// Push is ignored when full (unless popping the same cycle); pop is ignored when empty.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_req,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t        mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between WB (always wins, zero latency) and the MDU
// (cut-through or FIFO-buffered); MDU is back-pressured via mdu_ready, front end via bubble_req.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     pipe_wb_valid,
  input  reg_idx_t pipe_wb_rd,
  input  word_t    pipe_wb_data,
  input  logic     mdu_valid,
  input  reg_idx_t mdu_rd,
  input  word_t    mdu_data,
  output logic     mdu_ready,
  input  logic     issue_valid,
  input  reg_idx_t issue_rd,
  input  reg_idx_t chk_rs1,
  input  reg_idx_t chk_rs2,
  output logic     busy_rs1,
  output logic     busy_rs2,
  output logic     busy_issue_rd,
  output logic     bubble_req,
  output logic     rf_load,
  output reg_idx_t rf_dest,
  output word_t    rf_in
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic          ready_q;
  logic [SW-1:0] starve_q;
  logic [31:0]   pend_q;
  logic [31:0]   pend_next;

  wb_req_t  head;
  wb_req_t  mdu_req;
  logic     full;
  logic     empty;
  logic     pipe_eff;
  logic     accept;
  logic     cut;
  logic     push;
  logic     pop;
  logic     mdu_wr;
  reg_idx_t mdu_wr_rd;

  assign pipe_eff  = rst && pipe_wb_valid && (pipe_wb_rd != '0);
  assign mdu_ready = ready_q && !full;
  assign accept    = mdu_valid && mdu_ready;
  assign pop       = rst && !pipe_eff && !empty;
  assign cut       = !pipe_eff && empty && accept && (mdu_rd != '0);
  // Results for x0 are accepted but never stored or written.
  assign push      = accept && (mdu_rd != '0) && !cut;
  assign mdu_wr    = pop || cut;
  assign mdu_wr_rd = pop ? head.rd : mdu_rd;
  assign mdu_req   = '{rd: mdu_rd, data: mdu_data};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_req (mdu_req),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    rf_load = 1'b0;
    rf_dest = '0;
    rf_in   = '0;
    if (pipe_eff) begin
      rf_load = 1'b1;
      rf_dest = pipe_wb_rd;
      rf_in   = pipe_wb_data;
    end else if (pop) begin
      rf_load = 1'b1;
      rf_dest = head.rd;
      rf_in   = head.data;
    end else if (cut) begin
      rf_load = 1'b1;
      rf_dest = mdu_rd;
      rf_in   = mdu_data;
    end
  end

  // A register being written from the MDU path this cycle is forwarded by regfile.
  assign busy_rs1      = pend_q[chk_rs1]  && !(mdu_wr && (mdu_wr_rd == chk_rs1));
  assign busy_rs2      = pend_q[chk_rs2]  && !(mdu_wr && (mdu_wr_rd == chk_rs2));
  assign busy_issue_rd = pend_q[issue_rd] && !(mdu_wr && (mdu_wr_rd == issue_rd));

  assign bubble_req = (starve_q == SW'(STARVE_LIMIT)) || full;

  always_comb begin
    pend_next = pend_q;
    if (mdu_wr) pend_next[mdu_wr_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) pend_next[issue_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q  <= 1'b0;
      pend_q   <= '0;
      starve_q <= '0;
    end else begin
      ready_q <= 1'b1;
      pend_q  <= pend_next;
      // A non-empty FIFO that is not popping means the pipe owns the port.
      if (empty || pop)                        starve_q <= '0;
      else if (starve_q != SW'(STARVE_LIMIT))  starve_q <= starve_q + SW'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic,
// every output compared each cycle against a queue/array model of the arbiter.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        busy_issue_rd;
  logic        bubble_req;
  logic        rf_load;
  logic [4:0]  rf_dest;
  logic [31:0] rf_in;

  regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .busy_issue_rd(busy_issue_rd),
    .bubble_req(bubble_req),
    .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Behavioural model state
  wb_req_t     q[$];
  bit [31:0]   sb;
  int          wcnt;
  bit          up;

  // Expectations for the current cycle
  logic        e_load, e_ready, e_bub, e_acc, e_pop, e_cut, e_push, e_mwr;
  logic [4:0]  e_dest, e_mrd;
  logic [31:0] e_in;

  logic [4:0]  iss_q[$];

  task automatic chk1(input string nm, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk5(input string nm, input logic [4:0] act, input logic [4:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    sb   = '0;
    wcnt = 0;
    up   = 1'b0;
  endtask

  // Expected port outcome for the inputs currently applied.
  task automatic calc();
    logic pe;
    pe      = rst && pipe_wb_valid && (pipe_wb_rd != 0);
    e_ready = rst && up && (q.size() < DEPTH);
    e_acc   = mdu_valid && e_ready;
    e_pop   = rst && !pe && (q.size() > 0);
    e_cut   = !pe && (q.size() == 0) && e_acc && (mdu_rd != 0);
    e_push  = e_acc && (mdu_rd != 0) && !e_cut;
    e_load  = 1'b0;
    e_dest  = '0;
    e_in    = '0;
    if (pe) begin
      e_load = 1'b1; e_dest = pipe_wb_rd; e_in = pipe_wb_data;
    end else if (e_pop) begin
      e_load = 1'b1; e_dest = q[0].rd; e_in = q[0].data;
    end else if (e_cut) begin
      e_load = 1'b1; e_dest = mdu_rd; e_in = mdu_data;
    end
    e_mwr = e_pop || e_cut;
    e_mrd = e_pop ? q[0].rd : mdu_rd;
    e_bub = rst && ((wcnt == LIMIT) || (q.size() == DEPTH));
  endtask

  function automatic logic ebusy(input logic [4:0] r);
    return rst && sb[r] && !(e_mwr && (e_mrd == r));
  endfunction

  task automatic cmp_all();
    chk1 ("rf_load",       rf_load,       e_load);
    chk5 ("rf_dest",       rf_dest,       e_dest);
    chk32("rf_in",         rf_in,         e_in);
    chk1 ("mdu_ready",     mdu_ready,     e_ready);
    chk1 ("bubble_req",    bubble_req,    e_bub);
    chk1 ("busy_rs1",      busy_rs1,      ebusy(chk_rs1));
    chk1 ("busy_rs2",      busy_rs2,      ebusy(chk_rs2));
    chk1 ("busy_issue_rd", busy_issue_rd, ebusy(issue_rd));
    if (issue_valid) chk1("issue_on_busy", busy_issue_rd, 1'b0);
  endtask

  // Advance one clock; model state follows the rules for the inputs just checked.
  task automatic adv();
    int osz;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      osz = q.size();
      if (e_pop)  void'(q.pop_front());
      if (e_push) q.push_back('{rd: mdu_rd, data: mdu_data});
      if (osz == 0 || e_pop) wcnt = 0;
      else if (wcnt < LIMIT) wcnt++;
      if (e_mwr) sb[e_mrd] = 1'b0;
      if (issue_valid && issue_rd != 0) sb[issue_rd] = 1'b1;
      up = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drv(input int pv, input int prd, input int pd, input int mv, input int mrd,
                     input int md, input int iv, input int ird, input int r1, input int r2);
    pipe_wb_valid = (pv != 0);
    pipe_wb_rd    = 5'(prd);
    pipe_wb_data  = 32'(pd);
    mdu_valid     = (mv != 0);
    mdu_rd        = 5'(mrd);
    mdu_data      = 32'(md);
    issue_valid   = (iv != 0);
    issue_rd      = 5'(ird);
    chk_rs1       = 5'(r1);
    chk_rs2       = 5'(r2);
    calc();
    #1;
    cmp_all();
  endtask

  task automatic idle(input int r1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  task automatic issue(input int rd);
    drv(0, 0, 0, 0, 0, 0, 1, rd, 0, 0);
    adv();
  endtask

  initial begin
    logic       hold;
    logic [4:0] cand;

    model_reset();
    rst = 1'b0;
    @(negedge clk);
    // Reset values, with live inputs that would otherwise write
    drv(1, 3, 32'hdead, 1, 5, 1, 1, 6, 6, 3);
    chk1("rst_load", rf_load, 1'b0);
    chk1("rst_ready", mdu_ready, 1'b0);
    adv();
    rst = 1'b1;
    idle(0);
    chk1("ready_release_cycle", mdu_ready, 1'b0);
    adv();
    idle(0);
    chk1("ready_up", mdu_ready, 1'b1);
    adv();

    // Cut-through
    issue(5);
    idle(5);
    chk1("busy5_pending", busy_rs1, 1'b1);
    adv();
    drv(0, 0, 0, 1, 5, 32'h1234, 0, 0, 5, 0);
    chk1 ("cut_load", rf_load, 1'b1);
    chk5 ("cut_dest", rf_dest, 5'd5);
    chk32("cut_in", rf_in, 32'h1234);
    chk1 ("cut_busy_bypass", busy_rs1, 1'b0);
    adv();
    idle(5);
    chk1("busy5_cleared", busy_rs1, 1'b0);
    adv();

    // Conflict: pipe wins, MDU entry drains next idle cycle
    issue(7);
    drv(1, 3, 32'haaaa, 1, 7, 32'h7777, 0, 0, 7, 0);
    chk5("conf_dest_pipe", rf_dest, 5'd3);
    chk1("conf_busy7", busy_rs1, 1'b1);
    adv();
    idle(7);
    chk5 ("conf_dest_mdu", rf_dest, 5'd7);
    chk32("conf_in_mdu", rf_in, 32'h7777);
    chk1 ("conf_busy7_bypass", busy_rs1, 1'b0);
    adv();

    // Starvation
    issue(10);
    drv(1, 4, 1, 1, 10, 32'h1010, 0, 0, 10, 0);
    adv();
    for (int k = 1; k <= 5; k++) begin
      drv(1, 4, k, 0, 0, 0, 0, 0, 10, 0);
      chk1("starve_bubble", bubble_req, (k == 5));
      adv();
    end
    idle(10);
    chk5("starve_drain_dest", rf_dest, 5'd10);
    chk1("starve_bubble_hold", bubble_req, 1'b1);
    adv();
    idle(10);
    chk1("starve_bubble_drop", bubble_req, 1'b0);
    adv();

    // Full FIFO, held third offer, ordering
    issue(11);
    issue(12);
    issue(13);
    drv(1, 4, 0, 1, 11, 32'h11, 0, 0, 0, 0);
    adv();
    drv(1, 4, 0, 1, 12, 32'h12, 0, 0, 0, 0);
    adv();
    drv(1, 4, 0, 1, 13, 32'h13, 0, 0, 0, 0);
    chk1("full_ready", mdu_ready, 1'b0);
    chk1("full_bubble", bubble_req, 1'b1);
    adv();
    drv(0, 0, 0, 1, 13, 32'h13, 0, 0, 0, 0);
    chk5("full_first", rf_dest, 5'd11);
    adv();
    drv(0, 0, 0, 1, 13, 32'h13, 0, 0, 0, 0);
    chk5("full_second", rf_dest, 5'd12);
    chk1("full_ready_back", mdu_ready, 1'b1);
    adv();
    idle(0);
    chk5 ("full_third", rf_dest, 5'd13);
    chk32("full_third_in", rf_in, 32'h13);
    adv();

    // x0 handling and same-cycle set/clear
    issue(14);
    drv(1, 4, 0, 1, 14, 32'h14, 0, 0, 0, 0);
    adv();
    drv(1, 0, 32'hbad, 0, 0, 0, 0, 0, 0, 0);
    chk5("x0_pipe_drain", rf_dest, 5'd14);
    adv();
    drv(0, 0, 0, 1, 0, 32'hbeef, 0, 0, 0, 0);
    chk1("x0_mdu_drop", rf_load, 1'b0);
    adv();
    idle(0);
    chk1("x0_mdu_not_queued", rf_load, 1'b0);
    adv();
    issue(9);
    drv(1, 4, 0, 1, 9, 32'h99, 0, 0, 0, 0);
    adv();
    drv(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    chk5("setclr_dest", rf_dest, 5'd9);
    adv();
    idle(9);
    chk1("setclr_set_wins", busy_rs1, 1'b1);
    adv();

    // Reset mid-operation
    issue(20);
    issue(21);
    drv(1, 4, 0, 1, 20, 32'h20, 0, 0, 0, 0);
    adv();
    drv(1, 4, 0, 1, 21, 32'h21, 0, 0, 0, 0);
    adv();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 20, 21);
    chk1("mid_rst_load", rf_load, 1'b0);
    chk1("mid_rst_busy1", busy_rs1, 1'b0);
    chk1("mid_rst_busy2", busy_rs2, 1'b0);
    chk1("mid_rst_ready", mdu_ready, 1'b0);
    adv();
    rst = 1'b1;
    idle(20);
    chk1("post_rst_no_write", rf_load, 1'b0);
    adv();
    idle(9);
    chk1("post_rst_no_write2", rf_load, 1'b0);
    chk1("post_rst_busy9", busy_rs1, 1'b0);
    adv();

    // Randomized traffic
    iss_q.delete();
    mdu_valid = 1'b0;
    e_acc     = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500 || i == 1501) rst = 1'b0;
      else rst = 1'b1;
      hold = rst && mdu_valid && !e_acc;
      if (!rst) iss_q.delete();
      if (!hold) begin
        mdu_valid = 1'b0;
        mdu_rd    = '0;
        mdu_data  = $urandom;
        if (rst && iss_q.size() > 0 && $urandom_range(0, 2) == 0) begin
          mdu_valid = 1'b1;
          mdu_rd    = iss_q.pop_front();
        end else if ($urandom_range(0, 19) == 0) begin
          mdu_valid = 1'b1;
        end
      end
      pipe_wb_valid = ($urandom_range(0, 9) < 6);
      if (e_bub && $urandom_range(0, 1) == 0) pipe_wb_valid = 1'b0;
      pipe_wb_rd   = 5'($urandom_range(0, 31));
      pipe_wb_data = $urandom;
      chk_rs1      = 5'($urandom_range(0, 31));
      chk_rs2      = 5'($urandom_range(0, 31));
      calc();
      cand        = 5'($urandom_range(0, 31));
      issue_rd    = cand;
      issue_valid = ($urandom_range(0, 3) == 0) && !ebusy(cand);
      if (issue_valid && rst && cand != 0) iss_q.push_back(cand);
      #1;
      cmp_all();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
